// File: rtl/stitch_pipeline_egress.sv
// Credit-managed egress FIFO at the tail of a fixed-latency pipeline.
// Optional sticky error detection is enabled by defining STITCH_EGRESS_ERR_CHECK_EN.
module stitch_pipeline_egress #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    output logic                       can_issue,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a word leaves when out_valid && out_ready on a rising edge;
    // in_valid is a push that cannot be back-pressured, so capacity is
    // reserved upstream through issue/can_issue credits.

    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full;
    logic pop;
    logic push_ok;
    logic credit_inc;

    assign full       = (count_q == DEPTH_C);
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = in_valid && (!full || pop);
    assign can_issue  = (credits_q < DEPTH_C);
    assign credit_inc = issue && can_issue;

    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        case ({credit_inc, pop})
            2'b10:   credits_d = credits_q + CW'(1);
            // Guard against pops of words that were never issued.
            2'b01:   credits_d = (credits_q != '0) ? credits_q - CW'(1) : credits_q;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage is intentionally not reset; out_valid qualifies out_data.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef STITCH_EGRESS_ERR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((issue && !can_issue) || (in_valid && full && !pop)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign overflow_err = err_q;
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_stitch_pipeline_egress.sv
// Self-checking bench for stitch_pipeline_egress against a queue-based reference model.
module tb_stitch_pipeline_egress;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         issue = 1'b0;
  logic         can_issue;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic         overflow_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  int           m_credits = 0;
  bit           m_err = 1'b0;

  stitch_pipeline_egress #(.DATA_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .issue(issue), .can_issue(can_issue),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    exp_q.delete();
    m_credits = 0;
    m_err = 1'b0;
  endfunction

  // Applies the current input values as one clock cycle of the rules.
  function automatic void model_step();
    bit do_pop, can, is_full;
    do_pop  = (exp_q.size() != 0) && out_ready;
    can     = (m_credits < D);
    is_full = (exp_q.size() == D);
`ifdef STITCH_EGRESS_ERR_CHECK_EN
    if ((issue && !can) || (in_valid && is_full && !do_pop)) m_err = 1'b1;
`endif
    if (do_pop) void'(exp_q.pop_front());
    if (in_valid && (!is_full || do_pop)) exp_q.push_back(in_data);
    if (issue && can) m_credits++;
    if (do_pop) m_credits--;
    if (m_credits < 0) m_credits = 0;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || can_issue !== 1'b1 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d out_valid=%b can_issue=%b err=%b required 0/0/1/0",
               count, out_valid, can_issue, overflow_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] want;
    for (int i = 0; i < D; i++) begin
      issue = 1'b1;
      cycle();
    end
    issue = 1'b0;
    checks++;
    if (can_issue !== 1'b0) begin
      errors++;
      $display("FAIL fill_can_issue: got %b required 0", can_issue);
    end
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hA0 + i);
      cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || out_valid !== 1'b1 || out_data !== W'(32'hA0)) begin
      errors++;
      $display("FAIL fill_state: count=%0d out_valid=%b out_data=%h required 4/1/a0",
               count, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      want = W'(32'hA0 + i);
      checks++;
      if (out_data !== want || out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h required %h", i, out_data, want);
      end
      cycle();
      if (i == 0) begin
        checks++;
        if (can_issue !== 1'b1) begin
          errors++;
          $display("FAIL drain_can_issue: got %b required 1", can_issue);
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d out_valid=%b required 0/0", count, out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hD0 + i);
      cycle();
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = W'(32'hB0 + i);
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL full_pp_data[%0d]: got %h required %h", i, out_data, exp_q[0]);
      end
      cycle();
      checks++;
      if (count !== 3'd4) begin
        errors++;
        $display("FAIL full_pp_count[%0d]: got %0d required 4", i, count);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < D; i++) begin
      checks++;
      if (out_data !== W'(32'hB6 + i)) begin
        errors++;
        $display("FAIL full_pp_tail[%0d]: got %h required %h", i, out_data, W'(32'hB6 + i));
      end
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic exp_err;
`ifdef STITCH_EGRESS_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    issue = 1'b1;
    for (int i = 0; i < D + 1; i++) cycle();
    issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (overflow_err !== exp_err || can_issue !== 1'b0) begin
        errors++;
        $display("FAIL overflow[%0d]: err=%b can_issue=%b required %b/0",
                 i, overflow_err, can_issue, exp_err);
      end
      cycle();
    end
    test_reset();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      issue = 1'b1; in_valid = 1'b1; in_data = W'($urandom);
      cycle();
    end
    idle_inputs();
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL async_pre: count=%0d required 3", count);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || can_issue !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: out_valid=%b count=%0d can_issue=%b required 0/0/1",
               out_valid, count, can_issue);
    end
    rst = 1'b0;
    #1;
    in_valid = 1'b1; in_data = W'(32'hC0);
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(32'hC0) || count !== 3'd1) begin
      errors++;
      $display("FAIL async_push: out_valid=%b out_data=%h count=%0d required 1/c0/1",
               out_valid, out_data, count);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 400; i++) begin
      issue     = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      checks++;
      if (count !== 3'(exp_q.size()) || out_valid !== (exp_q.size() != 0) ||
          can_issue !== (m_credits < D) || overflow_err !== m_err ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d/%0d can_issue=%b/%b err=%b/%b data=%h/%h",
                 i, count, exp_q.size(), can_issue, (m_credits < D), overflow_err, m_err,
                 out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
